// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the ALU round-robin scheduler
package alu_sched_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } sched_state_e;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational two's-complement add/subtract unit
module alu_addsub
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] z_o
);

  // Result wraps modulo 2^WIDTH; carry and borrow are intentionally dropped
  always_comb begin
    z_o = (op_i == ALU_SUB) ? (a_i - b_i) : (a_i + b_i);
  end

endmodule

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin scheduler sharing one add/sub ALU among requesters
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  WIDTH   = DEFAULT_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_z,
  output logic [15:0]              op_count
);

  sched_state_e    state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic [15:0]     op_count_q, op_count_d;

  logic            slot_free;
  logic            grant_found;
  logic            accept;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;

  logic [WIDTH-1:0] alu_a, alu_b, alu_z;
  alu_op_e          alu_op;

  assign rsp_valid = (state_q == S_FULL);
  assign slot_free = !rsp_valid || rsp_ready;
  assign accept    = |req_ready;

  // Search from the slot after the last winner so idle cycles never reorder priority
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    req_ready = '0;
    if (slot_free && grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign alu_a  = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign alu_b  = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign alu_op = alu_op_e'(req_op[grant_idx]);

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i (alu_a),
    .b_i (alu_b),
    .op_i(alu_op),
    .z_o (alu_z)
  );

  // Response slot FSM plus capture of the granted result, pointer and counter
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_z_d    = rsp_z_q;
    op_count_d = op_count_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (!accept && rsp_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      rr_ptr_d   = grant_idx;
      rsp_id_d   = grant_idx;
      rsp_z_d    = alu_z;
      op_count_d = op_count_q + 16'd1;
    end
  end

  // State register; pointer resets to the last index so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      rsp_id_q   <= '0;
      rsp_z_q    <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_z_q    <= rsp_z_d;
      op_count_q <= op_count_d;
    end
  end

  assign rsp_id   = rsp_id_q;
  assign rsp_z    = rsp_z_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - directed self-checking bench for alu_rr_sched
module tb_alu_rr_sched;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_op = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_z;
  logic [15:0]    op_count;

  int total = 0;
  int bad   = 0;

  alu_rr_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_op   (req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_z    (rsp_z),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Requester obligation: a pending request holds valid and operands until accepted
  logic [N-1:0]   pend_q;
  logic [N*W-1:0] hold_a_q, hold_b_q;
  logic [N-1:0]   hold_op_q;
  always @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else begin
      pend_q    <= req_valid & ~req_ready;
      hold_a_q  <= req_a;
      hold_b_q  <= req_b;
      hold_op_q <= req_op;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (pend_q[i]) begin
          assert (req_valid[i] && req_a[i*W +: W] == hold_a_q[i*W +: W] &&
                  req_b[i*W +: W] == hold_b_q[i*W +: W] && req_op[i] == hold_op_q[i])
            else $error("requester %0d changed a pending request", i);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i]       = op;
    req_valid[i]    = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_z !== 32'h0) begin bad++; $display("FAIL reset_z: got %h want 0", rsp_z); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", op_count); end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(0, 32'd5, 32'd3, 1'b0);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    total++; if (rsp_z !== 32'd8) begin bad++; $display("FAIL single_z: got %h want 8", rsp_z); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", op_count); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int           exp_g [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] exp_z [5] = '{32'hFFFF_FFFF, 32'd9, 32'd19, 32'd29, 32'hFFFF_FFFF};
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'(10 * i), 32'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_rdy = '0;
      exp_rdy[exp_g[k]] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      tick();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", k, rsp_valid); end
      total++; if (rsp_id !== IDW'(exp_g[k])) begin bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, rsp_id, exp_g[k]); end
      total++; if (rsp_z !== exp_z[k]) begin bad++; $display("FAIL rr_z[%0d]: got %h want %h", k, rsp_z, exp_z[k]); end
    end
    total++; if (op_count !== 16'd5) begin bad++; $display("FAIL rr_count: got %0d want 5", op_count); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", rsp_valid); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", op_count); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    req_valid = '0;
    tick();
    rst = 1'b0;
    set_req(0, 32'd1, 32'd1, 1'b0);
    set_req(2, 32'd9, 32'd4, 1'b1);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first: got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    total++; if (rsp_z !== 32'd2 || rsp_id !== 2'd0) begin bad++; $display("FAIL mid_rsp0: got z=%h id=%0d want z=2 id=0", rsp_z, rsp_id); end
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_second: got %b want 0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    total++; if (rsp_z !== 32'd5 || rsp_id !== 2'd2) begin bad++; $display("FAIL mid_rsp2: got z=%h id=%0d want z=5 id=2", rsp_z, rsp_id); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 32'd5, 32'd3, 1'b0);
    tick();
    req_valid[0] = 1'b0;
    rsp_ready = 1'b0;
    set_req(1, 32'd100, 32'd50, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
      total++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd8 || rsp_id !== 2'd0) begin bad++; $display("FAIL bp_hold[%0d]: got v=%b z=%h id=%0d want v=1 z=8 id=0", k, rsp_valid, rsp_z, rsp_id); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release: got %b want 0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd50 || rsp_id !== 2'd1) begin bad++; $display("FAIL bp_rsp: got v=%b z=%h id=%0d want v=1 z=32 id=1", rsp_valid, rsp_z, rsp_id); end
  endtask

  task automatic test_wrap();
    set_req(2, 32'h7FFF_FFFF, 32'd1, 1'b0);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_ready0: got %b want 0100", req_ready); end
    tick();
    set_req(2, 32'd0, 32'd1, 1'b1);
    total++; if (rsp_z !== 32'h8000_0000 || rsp_id !== 2'd2) begin bad++; $display("FAIL wrap_add: got z=%h id=%0d want z=80000000 id=2", rsp_z, rsp_id); end
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_ready1: got %b want 0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    total++; if (rsp_z !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_sub: got %h want ffffffff", rsp_z); end
  endtask

  task automatic test_fairness();
    do_reset();
    set_req(2, 32'd2, 32'd2, 1'b0);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL fair_first: got %b want 0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    total++; if (rsp_z !== 32'd4 || rsp_id !== 2'd2) begin bad++; $display("FAIL fair_rsp2: got z=%h id=%0d want z=4 id=2", rsp_z, rsp_id); end
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL fair_idle[%0d]: got %b want 0000", k, req_ready); end
      tick();
    end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL fair_drained: got %b want 0", rsp_valid); end
    set_req(0, 32'd1, 32'd0, 1'b0);
    set_req(3, 32'd3, 32'd0, 1'b0);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL fair_g3: got %b want 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    total++; if (rsp_z !== 32'd3 || rsp_id !== 2'd3) begin bad++; $display("FAIL fair_rsp3: got z=%h id=%0d want z=3 id=3", rsp_z, rsp_id); end
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_g0: got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    total++; if (rsp_z !== 32'd1 || rsp_id !== 2'd0) begin bad++; $display("FAIL fair_rsp0: got z=%h id=%0d want z=1 id=0", rsp_z, rsp_id); end
    total++; if (op_count !== 16'd3) begin bad++; $display("FAIL fair_count: got %0d want 3", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reset_mid();
    test_backpressure();
    test_wrap();
    test_fairness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Shares one add/subtract ALU datapath among NUM_REQ requesters.
- Round-robin arbitration; each requester uses a valid/ready request handshake.
- Results go to one registered response port, tagged with the requester id.
- Sits between the requester-side issue logic and the shared arithmetic unit; it is the only path into that unit.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 32, operand and result width in bits.
- ID_W, $clog2(NUM_REQ), width of the response tag; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or all-zero.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_op  in  NUM_REQ  operation select: 0 = add (a+b), 1 = subtract (a-b).
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that produced rsp_z.
- rsp_z  out  WIDTH  result.
- op_count  out  16  number of accepted operations; wraps modulo 2^16.

Behaviour:
- Reset values: rsp_valid=0, rsp_z=0, rsp_id=0, op_count=0, rr_ptr=NUM_REQ-1. With this rr_ptr, requester 0 wins first after reset.
- Reset is asynchronous and takes effect mid-operation. Any held or in-flight response is discarded, and req_ready is forced to 0 while rst is high.
- Slot-free condition: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - Applies only when slot_free=1.
  - Search req_valid starting at index rr_ptr+1, wrapping modulo NUM_REQ.
  - The first set bit wins, and only that bit of req_ready is driven high.
  - When slot_free=0, or no request is valid, req_ready is all zero.
- req_ready depends combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- Accept event: req_valid[g] && req_ready[g] for the granted index g. On the next edge:
  - rsp_z <= result of the ALU for (a[g], b[g], op[g]).
  - rsp_id <= g, rsp_valid <= 1.
  - rr_ptr <= g.
  - op_count <= op_count+1.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 operation per cycle while rsp_ready stays high.
- Response drain: rsp_valid && rsp_ready with no accept in the same cycle gives rsp_valid <= 0 next edge. Drain and accept in the same cycle overwrite the register with the new result; rsp_valid stays 1.
- Backpressure: while rsp_valid && !rsp_ready, rsp_z and rsp_id hold stable, and no grant is issued.
- Requester obligation: once req_valid[i] is raised, it and req_a/req_b/req_op for i hold stable until accepted. The bench checks this with an assertion.
- State machine, two states:
  - EMPTY (rsp_valid=0): goes to FULL on accept.
  - FULL (rsp_valid=1): stays FULL on drain+accept or on stall; goes to EMPTY on drain with no accept.
- Arithmetic:
  - Two's-complement, modulo 2^WIDTH; no carry, borrow, or overflow output.
  - 0x7FFFFFFF+1 = 0x80000000.
  - 0-1 = 0xFFFFFFFF.
- rr_ptr advances only on accept. Idle cycles do not disturb fairness order.
- A lone requester is granted every free cycle.
- No requester waits more than NUM_REQ-1 grants to others.

Decomposition:
- Shared package alu_sched_pkg:
  - typedef alu_op_e {ALU_ADD=1'b0, ALU_SUB=1'b1}.
  - typedef sched_state_e {S_EMPTY, S_FULL}.
  - Constant DEFAULT_WIDTH=32.
- Sub-module alu_addsub: purely combinational (a, b, op) -> z, WIDTH-parameterised, instantiated once. The scheduler holds all sequential state: rr_ptr, the response register and op_count.

Test Plan:
- Reset then single request: req0 a=5, b=3, op=add -> accepted in cycle 0; next cycle rsp_valid=1, rsp_z=8, rsp_id=0, op_count=1.
- All four requesters valid continuously with rsp_ready=1, req i: a=10*i, b=1, op=sub -> grants in order 0,1,2,3,0; rsp_z sequence 0xFFFFFFFF, 9, 19, 29; one response per cycle.
- Backpressure: rsp_valid=1 with rsp_z=8, rsp_ready=0 for 3 cycles, req1 valid -> req_ready all zero, rsp_z/rsp_id stable. rsp_ready=1 -> req1 granted that same cycle; its result appears next cycle.
- Wrap-around: a=0x7FFFFFFF, b=1, add -> rsp_z=0x80000000. Then a=0, b=1, sub -> 0xFFFFFFFF.
- Fairness after idle: req2 accepted, then 2 idle cycles, then req0 and req3 valid together -> req3 granted first, then req0.
- Reset mid-operation: rsp_valid=1 and op_count=5 with rst asserted asynchronously between edges -> rsp_valid=0 and op_count=0 immediately. After release, req0 has first priority.
